// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream in and instruction RAM write port of the loader
interface imem_loader_if #(parameter int ADDR_W = 9);
  logic [7:0] byte_in;
  logic byte_valid;
  logic byte_ready;
  logic we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0] wdata;
  modport master (output byte_in, byte_valid, input byte_ready, we, waddr, wdata);
  modport slave (input byte_in, byte_valid, output byte_ready, we, waddr, wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: unpacks a length-prefixed byte stream into instruction RAM words
module imem_loader #(
  parameter int DEPTH = 400,
  parameter int ADDR_W = 9
) (
  input logic clk,
  input logic rst,
  input logic start,
  imem_loader_if.slave bus,
  output logic cpu_hold,
  output logic busy,
  output logic done,
  output logic error
);
  localparam logic [2:0] IDLE = 3'd0, LEN_HI = 3'd1, LEN_LO = 3'd2, DATA = 3'd3,
                         WRITE = 3'd4, DONE = 3'd5, ERR = 3'd6;
  logic [2:0] state;
  logic [7:0] hi;
  logic [15:0] count;
  logic [ADDR_W-1:0] widx, waddr;
  logic [1:0] bidx;
  logic [23:0] sr;
  logic [31:0] wdata;
  logic xfer;
  logic [15:0] len;
  assign xfer = bus.byte_valid && bus.byte_ready;
  assign len = {hi, bus.byte_in};
  // every output is decoded from state or a register, never from the stream inputs
  assign bus.byte_ready = state == LEN_HI || state == LEN_LO || state == DATA;
  assign bus.we = state == WRITE;
  assign bus.waddr = waddr;
  assign bus.wdata = wdata;
  assign busy = state inside {LEN_HI, LEN_LO, DATA, WRITE};
  assign cpu_hold = busy || state == ERR;
  assign done = state == DONE;
  assign error = state == ERR;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hi <= '0;
      count <= '0;
      widx <= '0;
      bidx <= '0;
      sr <= '0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: if (start) begin
          state <= LEN_HI;
          widx <= '0;
          bidx <= '0;
        end
        LEN_HI: if (xfer) begin
          hi <= bus.byte_in;
          state <= LEN_LO;
        end
        LEN_LO: if (xfer) begin
          count <= len;
          state <= len == 16'd0 ? DONE : len > 16'(DEPTH) ? ERR : DATA;
        end
        DATA: if (xfer) begin
          sr <= {sr[15:0], bus.byte_in};
          bidx <= bidx + 2'd1;
          if (bidx == 2'd3) begin
            state <= WRITE;
            waddr <= widx;
            wdata <= {sr, bus.byte_in};
          end
        end
        WRITE: begin
          widx <= widx + 1'b1;
          state <= 16'(widx) + 16'd1 == count ? DONE : DATA;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven and directed checks of the program loader
module tb_imem_loader;
  logic clk = 0, rst = 1, start = 0;
  logic cpu_hold, busy, done, error;
  int tests = 0, fails = 0;
  logic [8:0] wa[$];
  logic [31:0] wd[$];
  imem_loader_if #(.ADDR_W(9)) bus();
  imem_loader #(.DEPTH(400), .ADDR_W(9)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus.slave),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.we) begin
    wa.push_back(bus.waddr);
    wd.push_back(bus.wdata);
  end
  typedef struct {
    logic st;
    logic bv;
    logic [7:0] b;
    logic [46:0] exp;
  } vec_t;
  vec_t vecs[11];
  function automatic logic [46:0] pk(logic rdy, logic w, logic [8:0] a, logic [31:0] d,
                                     logic h, logic bz, logic dn, logic er);
    return {rdy, w, a, d, h, bz, dn, er};
  endfunction
  function automatic logic [46:0] obs();
    return {bus.byte_ready, bus.we, bus.waddr, bus.wdata, cpu_hold, busy, done, error};
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic send_byte(logic [7:0] b, int gap);
    int n = 0;
    bus.byte_valid = 0;
    repeat (gap) tick();
    bus.byte_valid = 1;
    bus.byte_in = b;
    while (!bus.byte_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.byte_ready) begin
      fails++;
      tests++;
      $display("FAIL byte_ready timeout: got 0 expected 1");
    end
    tick();
    bus.byte_valid = 0;
  endtask
  task automatic send_word(logic [31:0] w, int maxgap);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], $urandom_range(0, maxgap));
  endtask
  task automatic wait_end();
    int n = 0;
    while (!done && !error && n < 50) begin
      tick();
      n++;
    end
    if (!done && !error) begin
      fails++;
      tests++;
      $display("FAIL end timeout: got done=0 error=0 expected one set");
    end
  endtask
  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask
  initial begin
    logic [31:0] w3[3];
    logic ok;
    bus.byte_valid = 0;
    bus.byte_in = 0;
    vecs[0]  = '{1, 0, 8'h00, pk(0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[1]  = '{0, 1, 8'h00, pk(1, 0, 0, 0, 1, 1, 0, 0)};
    vecs[2]  = '{0, 1, 8'h01, pk(1, 0, 0, 0, 1, 1, 0, 0)};
    vecs[3]  = '{0, 1, 8'h12, pk(1, 0, 0, 0, 1, 1, 0, 0)};
    vecs[4]  = '{0, 1, 8'h34, pk(1, 0, 0, 0, 1, 1, 0, 0)};
    vecs[5]  = '{0, 1, 8'h56, pk(1, 0, 0, 0, 1, 1, 0, 0)};
    vecs[6]  = '{0, 1, 8'h78, pk(1, 0, 0, 0, 1, 1, 0, 0)};
    vecs[7]  = '{0, 0, 8'h00, pk(0, 1, 0, 32'h12345678, 1, 1, 0, 0)};
    vecs[8]  = '{0, 0, 8'h00, pk(0, 0, 0, 32'h12345678, 0, 0, 1, 0)};
    vecs[9]  = '{0, 1, 8'hFF, pk(0, 0, 0, 32'h12345678, 0, 0, 1, 0)};
    vecs[10] = '{0, 1, 8'hEE, pk(0, 0, 0, 32'h12345678, 0, 0, 1, 0)};
    repeat (2) tick();
    rst = 0;
    for (int i = 0; i < 11; i++) begin
      start = vecs[i].st;
      bus.byte_valid = vecs[i].bv;
      bus.byte_in = vecs[i].b;
      chk($sformatf("vec%0d", i), 64'(obs()), 64'(vecs[i].exp));
      tick();
    end
    start = 0;
    bus.byte_valid = 0;
    chk("vec we count", wa.size(), 1);
    clear_log();
    w3 = '{32'hA0000001, 32'hB0000002, 32'hC0000003};
    pulse_start();
    send_byte(8'h00, 2);
    send_byte(8'h03, 1);
    for (int i = 0; i < 3; i++) send_word(w3[i], 3);
    wait_end();
    chk("len3 we count", wa.size(), 3);
    for (int i = 0; i < 3 && i < wa.size(); i++) begin
      chk($sformatf("len3 waddr%0d", i), 64'(wa[i]), 64'(i));
      chk($sformatf("len3 wdata%0d", i), 64'(wd[i]), 64'(w3[i]));
    end
    bus.byte_valid = 1;
    tick();
    chk("len3 ready after done", 64'(bus.byte_ready), 0);
    chk("len3 done/hold", {done, cpu_hold}, 2'b10);
    bus.byte_valid = 0;
    clear_log();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h91, 0);
    chk("401 err/hold/busy/ready", {error, cpu_hold, busy, bus.byte_ready, done}, 5'b11000);
    tick();
    chk("401 no we", wa.size(), 0);
    pulse_start();
    chk("restart from err", {error, busy, cpu_hold}, 3'b011);
    send_byte(8'h01, 0);
    send_byte(8'h90, 0);
    for (int i = 0; i < 400; i++) send_word(32'h5000_0000 + 32'(i * 7), 0);
    wait_end();
    chk("400 done", {done, error}, 2'b10);
    chk("400 we count", wa.size(), 400);
    ok = 1;
    for (int i = 0; i < wa.size(); i++)
      if (wa[i] !== 9'(i) || wd[i] !== 32'h5000_0000 + 32'(i * 7)) ok = 0;
    chk("400 all words", 64'(ok), 1);
    if (wa.size() > 0) chk("400 last waddr", 64'(wa[wa.size()-1]), 399);
    clear_log();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("len0 done", {done, busy, cpu_hold, bus.byte_ready}, 4'b1000);
    tick();
    chk("len0 no we", wa.size(), 0);
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'h11223344, 1);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    rst = 1;
    tick();
    chk("rst mid-load outputs", 64'(obs()), 0);
    rst = 0;
    clear_log();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(32'hDEADBEEF, 2);
    wait_end();
    chk("reload we count", wa.size(), 1);
    if (wa.size() > 0) chk("reload waddr/wdata", {23'h0, wa[0], wd[0]}, {23'h0, 9'd0, 32'hDEADBEEF});
    clear_log();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hCA, 0);
    send_byte(8'hFE, 0);
    pulse_start();
    chk("start in DATA ignored", {busy, bus.byte_ready, done}, 3'b110);
    send_byte(8'hBA, 0);
    send_byte(8'hBE, 0);
    wait_end();
    chk("start-ignored we count", wa.size(), 1);
    if (wd.size() > 0) chk("start-ignored wdata", 64'(wd[0]), 64'(32'hCAFEBABE));
    clear_log();
    pulse_start();
    chk("start from done", {done, busy, cpu_hold}, 3'b011);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(32'h0BADF00D, 1);
    wait_end();
    if (wa.size() == 1) chk("second load word", {23'h0, wa[0], wd[0]}, {23'h0, 9'd0, 32'h0BADF00D});
    else chk("second load we count", wa.size(), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
